ov7670_fifo_ctrl: RTL and testbench
===================================

# ov7670_fifo_ctrl

Frame-capture sequencer for the OV7670 camera with its AL422B frame FIFO. It arms the FIFO write port for exactly one camera frame, bounded by VSYNC edges. It then drains the stored frame through the FIFO read port, packing byte pairs into 16-bit RGB565 pixels on a valid/ready stream for the VGA frame path. It sits between the I2C init controller (START) and the display buffer.

## Interface
- H_PIX, 320, pixels per line
- V_LINES, 240, lines per frame; frame size NPIX = H_PIX*V_LINES (76800 default)
- CNT_W, $clog2(H_PIX*V_LINES), pixel counter width (17 default)

- CLK  in  1  system clock; all logic is synchronous to its rising edge
- RST_N  in  1  reset, asynchronous, active-low
- START  in  1  level; high means sensor init is done and capture is allowed
- OV_VS  in  1  camera VSYNC, asynchronous; rising edge marks a frame boundary
- OV_DATA  in  8  FIFO read data
- OV_WRST  out  1  FIFO write-pointer reset, active-low
- OV_WREN  out  1  FIFO write enable, active-high
- OV_RRST  out  1  FIFO read-pointer reset, active-low
- OV_RCLK  out  1  FIFO read clock
- PIX_DATA  out  16  pixel {first byte, second byte}
- PIX_VALID  out  1  PIX_DATA holds an unconsumed pixel
- PIX_READY  in  1  sink accepts the pixel on a cycle where PIX_VALID&PIX_READY
- FRAME_DONE  out  1  one-cycle pulse after the last pixel of a frame is accepted
- BUSY  out  1  high in every state except IDLE

## Operation
- VSYNC handling: OV_VS passes through a 2-flop synchronizer. A rising edge (vs_rise) is detected on the synchronized value, giving 3 cycles of latency.
- Reset, and IDLE state, drive these values: OV_WRST=1, OV_WREN=0, OV_RRST=1, OV_RCLK=1, PIX_VALID=0, PIX_DATA=0, FRAME_DONE=0, BUSY=0, pixel count=0, phase=0. Reset is asynchronous and aborts any state immediately.
- States:
  - IDLE: if START=1, go to WAIT_VS.
  - WAIT_VS: on vs_rise, go to WRST.
  - WRST: hold OV_WRST=0 for exactly 2 cycles, then go to WRITE.
  - WRITE: OV_WREN=1 starting the first cycle in this state. On vs_rise, set OV_WREN=0 and go to RRST.
  - RRST: hold OV_RRST=0 through one 4-cycle RCLK pattern (0,1,0,1). Then set OV_RRST=1 and go to READ with phase=0.
  - READ: fetch NPIX pixels.
  - DONE: pulse FRAME_DONE for 1 cycle. Go to WAIT_VS if START=1, otherwise go to IDLE.
- Pixel fetch in READ uses a 2-bit phase counter. OV_RCLK = 0,1,0,1 in phases 0..3.
  - Phase 0 advances only when the output slot is free: !PIX_VALID | PIX_READY. Otherwise it holds with OV_RCLK=0.
  - Phases 1→2→3→0 are unconditional.
  - The high byte is sampled at the edge ending phase 1. The low byte is sampled at the edge ending phase 3. Each sample is one full CLK after the RCLK rise.
  - At the edge ending phase 3: load PIX_DATA={hi,lo}, set PIX_VALID=1, increment the pixel count.
- PIX_VALID clears on acceptance unless a new pixel loads on the same edge; a load takes priority.
- When the count reaches NPIX and the final pixel is accepted, reset the count to 0 and go to DONE.
- vs_rise in RRST, READ, DONE or IDLE is ignored. The stored frame stays intact because OV_WREN=0.
- If START falls mid-frame, the current frame completes. IDLE is entered from DONE.
- If START falls in WAIT_VS, go to IDLE on the next cycle.

## Timing
- Peak throughput: 1 pixel per 4 CLK. PIX_DATA is stable while PIX_VALID=1 and PIX_READY=0.
- From vs_rise, OV_WRST falls the next cycle and OV_WREN rises 2 cycles after that.
- OV_WREN falls the cycle after the second vs_rise.
- First PIX_VALID appears 8 cycles after entering RRST (4 cycles of RRST plus 4 of fetch).
- FRAME_DONE occurs the cycle after the last handshake.
- No combinational path from any input to any output; all outputs are registered.

## Test plan
- Reset values: RST_N=0 mid-READ with PIX_VALID=1 → all outputs return to their idle values asynchronously; after release, the block stays in IDLE while START=0.
- Full frame, PIX_READY=1 tied high, OV_DATA modelled from an incrementing FIFO model → exactly 76800 pixels, pixel n = {byte 2n, byte 2n+1}, one FRAME_DONE pulse, OV_RCLK rising-edge count = 2+153600.
- Write window: VS pulses at arbitrary spacing → WRST low for 2 cycles, WREN high exactly between the 1st and 2nd synchronized VS rise; extra VS pulses during READ cause no change.
- Backpressure: random PIX_READY at 30% duty → no pixel lost or duplicated, PIX_DATA stable while stalled, OV_RCLK held 0 during the stall.
- START deasserted mid-WRITE → the frame completes, FRAME_DONE pulses, then IDLE (BUSY=0) with no further WRST.
- Small parameters H_PIX=4, V_LINES=2 → 8 pixels, count wraps to 0, START held high → re-arms in WAIT_VS.

Source files
------------

// File: rtl/ov7670_fifo_ctrl.sv
// Frame-capture sequencer for an OV7670 camera backed by an AL422B frame FIFO.
// Opens the FIFO write window for exactly one frame between two VSYNC rising
// edges, then drains the stored frame through the FIFO read port and packs
// byte pairs into 16-bit RGB565 pixels on a valid/ready stream.
//
// Stream handshake: PIX_VALID rises when a new pixel is loaded into PIX_DATA
// and stays high, with PIX_DATA frozen, until a cycle where PIX_VALID and
// PIX_READY are both high; the pixel transfers on that rising CLK edge.
// PIX_VALID never depends combinationally on PIX_READY.
module ov7670_fifo_ctrl #(
  parameter int H_PIX   = 320,
  parameter int V_LINES = 240,
  parameter int CNT_W   = $clog2(H_PIX * V_LINES)
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic        OV_VS,
  input  logic [7:0]  OV_DATA,
  output logic        OV_WRST,
  output logic        OV_WREN,
  output logic        OV_RRST,
  output logic        OV_RCLK,
  output logic [15:0] PIX_DATA,
  output logic        PIX_VALID,
  input  logic        PIX_READY,
  output logic        FRAME_DONE,
  output logic        BUSY,
  output logic [2:0]  DBG_STATE
);

  localparam int NPIX = H_PIX * V_LINES;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NPIX - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_VS = 3'd1,
    S_WRST    = 3'd2,
    S_WRITE   = 3'd3,
    S_RRST    = 3'd4,
    S_READ    = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t           r_state;
  logic [1:0]       r_sub;
  logic [1:0]       r_phase;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last;
  logic [7:0]       r_hi;
  logic             r_vs_s1, r_vs_s2, r_vs_s3;
  logic             r_wrst, r_wren, r_rrst, r_rclk;
  logic [15:0]      r_pix_data;
  logic             r_pix_valid, r_frame_done, r_busy;

  state_t           w_nxt;
  logic [1:0]       w_sub_nxt;
  logic [1:0]       w_phase_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_last_nxt;
  logic [7:0]       w_hi_nxt;
  logic [15:0]      w_pix_data_nxt;
  logic             w_pix_valid_nxt;
  logic             w_wrst_nxt, w_wren_nxt, w_rrst_nxt, w_rclk_nxt;
  logic             w_frame_done_nxt, w_busy_nxt;
  logic             w_vs_rise, w_accept, w_slot_free;

  // VSYNC edge seen on the synchronized copy; the third flop holds its history
  assign w_vs_rise   = r_vs_s2 & ~r_vs_s3;
  assign w_accept    = r_pix_valid & PIX_READY;
  assign w_slot_free = ~r_pix_valid | PIX_READY;

  // State register plus every registered output and datapath flop
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= S_IDLE;
      r_sub        <= 2'd0;
      r_phase      <= 2'd0;
      r_cnt        <= '0;
      r_last       <= 1'b0;
      r_hi         <= 8'd0;
      r_vs_s1      <= 1'b0;
      r_vs_s2      <= 1'b0;
      r_vs_s3      <= 1'b0;
      r_wrst       <= 1'b1;
      r_wren       <= 1'b0;
      r_rrst       <= 1'b1;
      r_rclk       <= 1'b1;
      r_pix_data   <= 16'd0;
      r_pix_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_nxt;
      r_sub        <= w_sub_nxt;
      r_phase      <= w_phase_nxt;
      r_cnt        <= w_cnt_nxt;
      r_last       <= w_last_nxt;
      r_hi         <= w_hi_nxt;
      r_vs_s1      <= OV_VS;
      r_vs_s2      <= r_vs_s1;
      r_vs_s3      <= r_vs_s2;
      r_wrst       <= w_wrst_nxt;
      r_wren       <= w_wren_nxt;
      r_rrst       <= w_rrst_nxt;
      r_rclk       <= w_rclk_nxt;
      r_pix_data   <= w_pix_data_nxt;
      r_pix_valid  <= w_pix_valid_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  // Next-state decode and the sub-cycle counter used to time WRST and RRST
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:    if (START) w_nxt = S_WAIT_VS;
      S_WAIT_VS: if (!START) w_nxt = S_IDLE;
                 else if (w_vs_rise) w_nxt = S_WRST;
      S_WRST:    if (r_sub == 2'd1) w_nxt = S_WRITE;
      S_WRITE:   if (w_vs_rise) w_nxt = S_RRST;
      S_RRST:    if (r_sub == 2'd3) w_nxt = S_READ;
      S_READ:    if (r_last && w_accept) w_nxt = S_DONE;
      S_DONE:    w_nxt = START ? S_WAIT_VS : S_IDLE;
      default:   w_nxt = S_IDLE;
    endcase
    w_sub_nxt = (w_nxt != r_state) ? 2'd0 : r_sub + 2'd1;
  end

  // Pixel fetch: four-phase RCLK cycle, byte capture and output slot update
  always_comb begin
    w_phase_nxt     = r_phase;
    w_cnt_nxt       = r_cnt;
    w_last_nxt      = r_last;
    w_hi_nxt        = r_hi;
    w_pix_data_nxt  = r_pix_data;
    w_pix_valid_nxt = r_pix_valid;
    if (r_state == S_READ) begin
      w_pix_valid_nxt = r_pix_valid & ~PIX_READY;
      case (r_phase)
        2'd0: if (!r_last && w_slot_free) w_phase_nxt = 2'd1;
        2'd1: begin
          w_hi_nxt    = OV_DATA;
          w_phase_nxt = 2'd2;
        end
        2'd2: w_phase_nxt = 2'd3;
        default: begin
          // A load wins over acceptance; the slot was freed before phase 1
          w_pix_data_nxt  = {r_hi, OV_DATA};
          w_pix_valid_nxt = 1'b1;
          w_phase_nxt     = 2'd0;
          if (r_cnt == LAST_IDX) begin
            w_cnt_nxt  = '0;
            w_last_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      endcase
    end
    if (w_nxt != S_READ) begin
      w_phase_nxt     = 2'd0;
      w_cnt_nxt       = '0;
      w_last_nxt      = 1'b0;
      w_hi_nxt        = 8'd0;
      w_pix_data_nxt  = 16'd0;
      w_pix_valid_nxt = 1'b0;
    end
  end

  // Output decode from the next state so every output leaves a flop
  always_comb begin
    w_wrst_nxt       = (w_nxt != S_WRST);
    w_wren_nxt       = (w_nxt == S_WRITE);
    w_rrst_nxt       = (w_nxt != S_RRST);
    w_frame_done_nxt = (w_nxt == S_DONE);
    w_busy_nxt       = (w_nxt != S_IDLE);
    w_rclk_nxt       = 1'b1;
    if (w_nxt == S_RRST) w_rclk_nxt = w_sub_nxt[0];
    else if (w_nxt == S_READ) w_rclk_nxt = w_phase_nxt[0];
  end

  assign OV_WRST    = r_wrst;
  assign OV_WREN    = r_wren;
  assign OV_RRST    = r_rrst;
  assign OV_RCLK    = r_rclk;
  assign PIX_DATA   = r_pix_data;
  assign PIX_VALID  = r_pix_valid;
  assign FRAME_DONE = r_frame_done;
  assign BUSY       = r_busy;
  assign DBG_STATE  = r_state;

endmodule

// File: tb/tb_ov7670_fifo_ctrl.sv
// Bench for ov7670_fifo_ctrl on a small 8x4 frame, with an AL422B read-port
// model and a pixel scoreboard.
module tb_ov7670_fifo_ctrl;

  localparam int H    = 8;
  localparam int V    = 4;
  localparam int NPIX = H * V;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WAIT_VS = 3'd1;

  logic        CLK;
  logic        RST_N;
  logic        START;
  logic        OV_VS;
  logic [7:0]  OV_DATA = 8'd0;
  logic        OV_WRST, OV_WREN, OV_RRST, OV_RCLK;
  logic [15:0] PIX_DATA;
  logic        PIX_VALID;
  logic        PIX_READY;
  logic        FRAME_DONE, BUSY;
  logic [2:0]  DBG_STATE;

  ov7670_fifo_ctrl #(.H_PIX(H), .V_LINES(V)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .OV_VS(OV_VS), .OV_DATA(OV_DATA),
    .OV_WRST(OV_WRST), .OV_WREN(OV_WREN), .OV_RRST(OV_RRST), .OV_RCLK(OV_RCLK),
    .PIX_DATA(PIX_DATA), .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY),
    .FRAME_DONE(FRAME_DONE), .BUSY(BUSY), .DBG_STATE(DBG_STATE)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // AL422B read port: pointer clears on RCLK rise while RRST low, else the
  // addressed byte appears on the data bus and the pointer advances
  logic [7:0] fifo_mem [2*NPIX];
  int         rd_ptr = 0;
  always @(posedge OV_RCLK) begin
    if (!OV_RRST) rd_ptr = 0;
    else if (rd_ptr < 2*NPIX) begin
      OV_DATA = fifo_mem[rd_ptr];
      rd_ptr  = rd_ptr + 1;
    end
  end

  // scoreboard and monitor state
  logic [15:0] exp_q[$];
  logic [15:0] exp_pix;
  logic [15:0] held;
  int checks = 0, failures = 0;
  int cyc = 0, last_pop_cyc = -10;
  int pops = 0, fd_cnt = 0, wrst_cnt = 0, wren_cnt = 0, rises = 0;
  int ready_mode = 0;
  logic stall_prev = 1'b0, prev_rclk = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: monitor at the falling edge, then drive after the rising edge
  task automatic step();
    @(negedge CLK);
    cyc++;
    if (RST_N) begin
      if (PIX_VALID && PIX_READY) begin
        check("pix_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_pix = exp_q.pop_front();
          check("pix_data", 32'(PIX_DATA), 32'(exp_pix));
        end
        pops++;
        last_pop_cyc = cyc;
      end
      if (PIX_VALID && stall_prev) check("pix_stable", 32'(PIX_DATA), 32'(held));
      if (PIX_VALID && !PIX_READY) check("rclk_stall", 32'(OV_RCLK), 32'd0);
      if (FRAME_DONE) begin
        fd_cnt++;
        check("fd_latency", 32'(cyc - last_pop_cyc), 32'd1);
      end
      if (!OV_WRST) wrst_cnt++;
      if (OV_WREN) wren_cnt++;
      if (OV_RCLK && !prev_rclk && !FRAME_DONE) rises++;
      stall_prev = PIX_VALID && !PIX_READY;
      held       = PIX_DATA;
    end else begin
      stall_prev = 1'b0;
    end
    prev_rclk = OV_RCLK;
    @(posedge CLK);
    #1;
    case (ready_mode)
      0:       PIX_READY = 1'b1;
      1:       PIX_READY = ($urandom_range(0, 9) < 3);
      default: PIX_READY = 1'b0;
    endcase
  endtask

  task automatic pulse_vs();
    OV_VS = 1'b1;
    step();
    step();
    OV_VS = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wrst"},  32'(OV_WRST),    32'd1);
    check({tag, "_wren"},  32'(OV_WREN),    32'd0);
    check({tag, "_rrst"},  32'(OV_RRST),    32'd1);
    check({tag, "_rclk"},  32'(OV_RCLK),    32'd1);
    check({tag, "_valid"}, 32'(PIX_VALID),  32'd0);
    check({tag, "_data"},  32'(PIX_DATA),   32'd0);
    check({tag, "_fd"},    32'(FRAME_DONE), 32'd0);
    check({tag, "_busy"},  32'(BUSY),       32'd0);
  endtask

  // one captured frame: VS rises d cycles apart, extra VS pulses during READ
  task automatic run_frame(input int d, input int mode, input bit drop_start);
    int w0, e0, r0, p0, f0, i;
    logic [7:0] seed;
    ready_mode = mode;
    seed = 8'($urandom_range(0, 255));
    for (int k = 0; k < 2*NPIX; k++) fifo_mem[k] = seed + 8'(k);
    for (int n = 0; n < NPIX; n++) exp_q.push_back({fifo_mem[2*n], fifo_mem[2*n+1]});
    w0 = wrst_cnt; e0 = wren_cnt; r0 = rises; p0 = pops; f0 = fd_cnt;
    pulse_vs();
    for (int j = 0; j < d - 2; j++) begin
      if (drop_start && j == 6) START = 1'b0;
      step();
    end
    pulse_vs();
    for (i = 0; i < 60 && !PIX_VALID; i++) step();
    check("first_valid_seen", 32'(PIX_VALID), 32'd1);
    pulse_vs();
    repeat (3) step();
    pulse_vs();
    for (i = 0; i < 4000 && fd_cnt == f0; i++) step();
    check("frame_done_seen", 32'(fd_cnt - f0), 32'd1);
    check("state_after", 32'(DBG_STATE), drop_start ? 32'(ST_IDLE) : 32'(ST_WAIT_VS));
    check("busy_after", 32'(BUSY), drop_start ? 32'd0 : 32'd1);
    step();
    check("wrst_low_cycles", 32'(wrst_cnt - w0), 32'd2);
    check("wren_high_cycles", 32'(wren_cnt - e0), 32'(d - 2));
    check("rclk_rises", 32'(rises - r0), 32'(2 + 2*NPIX));
    check("pix_count", 32'(pops - p0), 32'(NPIX));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("fd_pulses", 32'(fd_cnt - f0), 32'd1);
  endtask

  initial begin
    int i, w0;
    RST_N = 1'b0; START = 1'b0; OV_VS = 1'b0; PIX_READY = 1'b0;
    for (int k = 0; k < 2*NPIX; k++) fifo_mem[k] = 8'(k);
    repeat (3) step();
    check_idle_outputs("reset");
    RST_N = 1'b1;
    repeat (6) step();
    check("idle_hold_busy", 32'(BUSY), 32'd0);
    check("idle_hold_state", 32'(DBG_STATE), 32'(ST_IDLE));

    // asynchronous reset while a pixel is stalled in the output slot
    ready_mode = 2;
    START = 1'b1;
    repeat (3) step();
    pulse_vs();
    repeat (8) step();
    pulse_vs();
    for (i = 0; i < 60 && !PIX_VALID; i++) step();
    check("rst_mid_read_valid", 32'(PIX_VALID), 32'd1);
    #2;
    RST_N = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    START = 1'b0;
    step();
    step();
    RST_N = 1'b1;
    repeat (6) step();
    check("post_rst_busy", 32'(BUSY), 32'd0);
    check("post_rst_state", 32'(DBG_STATE), 32'(ST_IDLE));

    // back-to-back frames with START held high, then one with START dropped
    START = 1'b1;
    repeat (3) step();
    run_frame($urandom_range(10, 20), 0, 1'b0);
    repeat (2) step();
    run_frame($urandom_range(10, 20), 1, 1'b0);
    repeat (2) step();
    run_frame($urandom_range(10, 20), 1, 1'b1);

    // no re-arm once idle with START low
    w0 = wrst_cnt;
    pulse_vs();
    repeat (10) step();
    check("idle_no_wrst", 32'(wrst_cnt - w0), 32'd0);
    check("idle_busy", 32'(BUSY), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
